// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - doubleword data-memory port (req/gnt/rvalid) between the LSU and memory
interface lsu_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV64I load/store unit, one access at a time; LSU_MISALIGN_EN enables the alignment fault check
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [6:0]     lsu_op,
    input  logic [63:0]    addr,
    input  logic [63:0]    wdata,
    input  logic [4:0]     rd,
    lsu_mem_ctrl_if.master mem,
    output logic           wb_valid,
    input  logic           wb_ready,
    output logic           wb_we,
    output logic [4:0]     wb_rd,
    output logic [63:0]    wb_data,
    output logic           wb_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [3:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [2:0]    a_q, a_d;
    logic [63:0]   addr_q, addr_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [4:0]    rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wb_we_q, wb_we_d;
    logic          wb_err_q, wb_err_d;
    logic [63:0]   wb_data_q, wb_data_d;

    logic          op_en, op_we, op_uns;
    logic [3:0]    op_size;
    logic          size_ok;
    logic          misaligned;
    logic          timeout_hit;
    logic [7:0]    in_mask;
    logic [63:0]   rd_shift;
    logic [63:0]   ld_ext;

    assign {op_en, op_we, op_size, op_uns} = lsu_op;
    assign size_ok = (op_size == 4'b0001) || (op_size == 4'b0010) ||
                     (op_size == 4'b0100) || (op_size == 4'b1000);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_EN
    // Natural-alignment check on the incoming address
    always_comb begin
        misaligned = (op_size[1] && addr[0]) ||
                     (op_size[2] && (addr[1:0] != 2'b00)) ||
                     (op_size[3] && (addr[2:0] != 3'b000));
    end
`else
    assign misaligned = 1'b0;
`endif

    // Byte enables for the incoming access; lanes shifted past byte 7 fall off
    always_comb begin
        in_mask = 8'h01 << addr[2:0];
        if (op_size[3]) begin
            in_mask = 8'hFF;
        end else if (op_size[2]) begin
            in_mask = 8'h0F << addr[2:0];
        end else if (op_size[1]) begin
            in_mask = 8'h03 << addr[2:0];
        end
    end

    // Move the addressed bytes of the read doubleword to the bottom, then sign/zero extend
    always_comb begin
        rd_shift = mem.mem_rdata >> {a_q, 3'b000};
        ld_ext   = rd_shift;
        if (size_q[2]) begin
            ld_ext = {{32{~uns_q & rd_shift[31]}}, rd_shift[31:0]};
        end else if (size_q[1]) begin
            ld_ext = {{48{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
        end else if (size_q[0]) begin
            ld_ext = {{56{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
        end
    end

    // State and transaction registers; reset abandons any access in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= 4'd0;
            uns_q     <= 1'b0;
            a_q       <= 3'd0;
            addr_q    <= 64'd0;
            wmask_q   <= 8'd0;
            wdata_q   <= 64'd0;
            rd_q      <= 5'd0;
            cnt_q     <= '0;
            wb_we_q   <= 1'b0;
            wb_err_q  <= 1'b0;
            wb_data_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            a_q       <= a_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            wb_we_q   <= wb_we_d;
            wb_err_q  <= wb_err_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Next state: accept in IDLE, handshake in REQ/WAIT with timeout, retire in DONE
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        a_d       = a_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        wb_we_d   = wb_we_q;
        wb_err_d  = wb_err_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    we_d      = op_we;
                    size_d    = op_size;
                    uns_d     = op_uns;
                    a_d       = addr[2:0];
                    addr_d    = {addr[63:3], 3'b000};
                    wmask_d   = in_mask;
                    wdata_d   = wdata << {addr[2:0], 3'b000};
                    rd_d      = rd;
                    cnt_d     = '0;
                    wb_we_d   = 1'b0;
                    wb_err_d  = 1'b0;
                    wb_data_d = 64'd0;
                    if (!op_en) begin
                        state_d = S_DONE;
                    end else if (!size_ok || misaligned) begin
                        wb_err_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    wb_err_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    wb_data_d = ld_ext;
                    wb_we_d   = 1'b1;
                    state_d   = S_DONE;
                end else if (timeout_hit) begin
                    wb_err_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs are pure functions of the registered state, so they hold steady under back-pressure
    always_comb begin
        in_ready      = (state_q == S_IDLE);
        wb_valid      = (state_q == S_DONE);
        mem.mem_req   = (state_q == S_REQ);
        mem.mem_we    = (state_q == S_REQ) && we_q;
        mem.mem_addr  = addr_q;
        mem.mem_wmask = wmask_q;
        mem.mem_wdata = wdata_q;
        wb_we         = wb_we_q;
        wb_rd         = rd_q;
        wb_data       = wb_data_q;
        wb_err        = wb_err_q;
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - randomized scoreboard bench for lsu_mem_ctrl
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
    localparam int TO = 6;

    localparam logic [6:0] OP_SB  = 7'b1_1_0001_0;
    localparam logic [6:0] OP_SD  = 7'b1_1_1000_0;
    localparam logic [6:0] OP_LB  = 7'b1_0_0001_0;
    localparam logic [6:0] OP_LBU = 7'b1_0_0001_1;
    localparam logic [6:0] OP_LH  = 7'b1_0_0010_0;
    localparam logic [6:0] OP_LW  = 7'b1_0_0100_0;
    localparam logic [6:0] OP_LWU = 7'b1_0_0100_1;
    localparam logic [6:0] OP_LD  = 7'b1_0_1000_0;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  lsu_op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_err;

    lsu_mem_ctrl_if mif();

    lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lsu_op   (lsu_op),
        .addr     (addr),
        .wdata    (wdata),
        .rd       (rd),
        .mem      (mif),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_err   (wb_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [63:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic        we;
        logic        err;
        logic [4:0]  rd;
        logic [63:0] data;
        int          lat;
        int          acc;
    } wb_exp_t;

    mem_exp_t mem_q[$];
    wb_exp_t  wb_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nbytes_of(input logic [3:0] s);
        case (s)
            4'b1000: return 8;
            4'b0100: return 4;
            4'b0010: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] mask_model(input logic [2:0] a, input int nb);
        logic [7:0] m;
        m = 8'h00;
        if (nb == 8) return 8'hFF;
        for (int k = 0; k < nb; k++)
            if (int'(a) + k < 8) m[int'(a) + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] store_model(input logic [63:0] wd, input logic [2:0] a);
        logic [63:0] d;
        d = 64'd0;
        for (int k = 0; int'(a) + k < 8; k++)
            d[8*(int'(a)+k) +: 8] = wd[8*k +: 8];
        return d;
    endfunction

    function automatic logic [63:0] load_model(input logic [63:0] rdat, input logic [2:0] a,
                                               input int nb, input logic uns);
        logic [63:0] v;
        v = 64'd0;
        for (int k = 0; k < nb; k++)
            if (int'(a) + k < 8) v[8*k +: 8] = rdat[8*(int'(a)+k) +: 8];
        if (!uns && nb < 8 && v[8*nb-1])
            for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic int pick_dly();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(TO, TO + 2));
        return int'($urandom_range(0, 3));
    endfunction

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic issue(input logic [6:0] op, input logic [63:0] ad, input logic [63:0] wd,
                         input logic [4:0] r, input int gd, input int rvd,
                         input logic [63:0] rdat, input bit expect_wb);
        mem_exp_t m;
        wb_exp_t  w;
        int       nb;
        int       waitc;
        bit       size_ok;
        bit       mis;
        in_valid = 1'b1;
        lsu_op   = op;
        addr     = ad;
        wdata    = wd;
        rd       = r;
        waitc    = 0;
        while (!in_ready) begin
            @(negedge clock);
            waitc++;
            if (waitc > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waitc);
                finish_now();
            end
        end
        size_ok = (op[4:1] == 4'b0001) || (op[4:1] == 4'b0010) ||
                  (op[4:1] == 4'b0100) || (op[4:1] == 4'b1000);
        nb  = nbytes_of(op[4:1]);
        mis = 1'b0;
`ifdef LSU_MISALIGN_EN
        mis = (nb == 2 && ad[0]) || (nb == 4 && ad[1:0] != 2'b00) || (nb == 8 && ad[2:0] != 3'b000);
`endif
        w.rd   = r;
        w.acc  = cyc;
        w.data = 64'd0;
        if (!op[6]) begin
            w.we = 1'b0; w.err = 1'b0; w.lat = 1;
        end else if (!size_ok || mis) begin
            w.we = 1'b0; w.err = 1'b1; w.lat = 1;
        end else begin
            m.we      = op[5];
            m.addr    = {ad[63:3], 3'b000};
            m.wmask   = mask_model(ad[2:0], nb);
            m.wdata   = store_model(wd, ad[2:0]);
            m.gnt_dly = gd;
            m.rv_dly  = rvd;
            m.rdata   = rdat;
            mem_q.push_back(m);
            if (gd >= TO) begin
                w.we = 1'b0; w.err = 1'b1; w.lat = 1 + TO;
            end else if (op[5]) begin
                w.we = 1'b0; w.err = 1'b0; w.lat = 2 + gd;
            end else if (rvd >= TO) begin
                w.we = 1'b0; w.err = 1'b1; w.lat = 2 + gd + TO;
            end else begin
                w.we = 1'b1; w.err = 1'b0; w.lat = 3 + gd + rvd;
                w.data = load_model(rdat, ad[2:0], nb, op[0]);
            end
        end
        if (expect_wb) wb_q.push_back(w);
        @(negedge clock);
        in_valid = 1'b0;
        lsu_op   = 7'($urandom);
        addr     = {$urandom, $urandom};
        wdata    = {$urandom, $urandom};
        rd       = 5'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (wb_q.size() != 0 || mem_q.size() != 0 || !in_ready) begin
            @(negedge clock);
            t++;
            if (t > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d wb and %0d mem expectations outstanding", wb_q.size(), mem_q.size());
                break;
            end
        end
    endtask

    task automatic chk_req(input mem_exp_t m);
        chk("mem_req", mif.mem_req, 1);
        chk("mem_we", mif.mem_we, m.we);
        chk("mem_addr", mif.mem_addr, m.addr);
        chk("mem_wmask", mif.mem_wmask, m.wmask);
        chk("mem_wdata", mif.mem_wdata, m.wdata);
    endtask

    // Memory responder: checks each request against the model and replays its scripted delays
    initial begin
        mem_exp_t m;
        bit granted;
        bit aborted;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 64'd0;
        forever begin
            @(negedge clock);
            mif.mem_rdata  = {$urandom, $urandom};
            mif.mem_gnt    = 1'($urandom_range(0, 1));
            mif.mem_rvalid = 1'($urandom_range(0, 1));
            if (!reset && mif.mem_req) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_req", mif.mem_req, 0);
                end else begin
                    m = mem_q.pop_front();
                    granted = 1'b0;
                    aborted = 1'b0;
                    for (int i = 0; i < TO; i++) begin
                        if (reset) begin aborted = 1'b1; break; end
                        chk_req(m);
                        mif.mem_gnt    = (i == m.gnt_dly);
                        mif.mem_rvalid = 1'($urandom_range(0, 1));
                        @(negedge clock);
                        if (i == m.gnt_dly) begin granted = 1'b1; break; end
                    end
                    mif.mem_gnt    = 1'b0;
                    mif.mem_rvalid = 1'b0;
                    if (!aborted && !reset) begin
                        chk("mem_req_low_after_req_phase", mif.mem_req, 0);
                    end
                    if (!aborted && granted && !m.we) begin
                        for (int j = 0; j < TO; j++) begin
                            if (reset) begin aborted = 1'b1; break; end
                            mif.mem_rvalid = (j == m.rv_dly);
                            mif.mem_rdata  = (j == m.rv_dly) ? m.rdata : {$urandom, $urandom};
                            mif.mem_gnt    = 1'($urandom_range(0, 1));
                            @(negedge clock);
                            if (j == m.rv_dly) break;
                        end
                        mif.mem_gnt    = 1'b0;
                        mif.mem_rvalid = 1'b0;
                    end
                end
            end
        end
    end

    // Writeback monitor: pops the scoreboard on each new result and re-checks it while held
    initial begin
        wb_exp_t e;
        bit holding;
        bit have;
        holding  = 1'b0;
        have     = 1'b0;
        wb_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                holding  = 1'b0;
                have     = 1'b0;
                wb_ready = 1'b0;
            end else if (wb_valid) begin
                chk("in_ready_low_while_done", in_ready, 0);
                if (!holding) begin
                    holding = 1'b1;
                    if (wb_q.size() == 0) begin
                        have = 1'b0;
                        chk("unexpected_wb_valid", wb_valid, 0);
                    end else begin
                        have = 1'b1;
                        e = wb_q.pop_front();
                        chk("wb_latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                end
                if (have) begin
                    chk("wb_we", wb_we, e.we);
                    chk("wb_err", wb_err, e.err);
                    chk("wb_rd", wb_rd, e.rd);
                    if (e.we) chk("wb_data", wb_data, e.data);
                end
                wb_ready = ($urandom_range(0, 2) != 0);
                if (wb_ready) holding = 1'b0;
            end else begin
                holding  = 1'b0;
                wb_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Stimulus: reset, directed cases, random traffic, then a reset in the middle of a load
    initial begin
        logic [6:0] op;
        logic [3:0] sz;
        reset    = 1'b1;
        in_valid = 1'b0;
        lsu_op   = 7'd0;
        addr     = 64'd0;
        wdata    = 64'd0;
        rd       = 5'd0;
        repeat (3) @(negedge clock);
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_mem_we", mif.mem_we, 0);
        chk("rst_mem_wmask", mif.mem_wmask, 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_mem_wdata", mif.mem_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_err", wb_err, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("in_ready_after_reset", in_ready, 1);

        issue(OP_SB,  64'h1003, 64'hAB, 5'd1, 0, 0, 64'd0, 1'b1);
        issue(OP_LB,  64'h2005, 64'd0, 5'd7, 0, 0, 64'h0000_8000_0000_0000, 1'b1);
        issue(OP_LBU, 64'h2005, 64'd0, 5'd8, 0, 0, 64'h0000_8000_0000_0000, 1'b1);
        issue(OP_LW,  64'h2004, 64'd0, 5'd9, 0, 0, 64'h8000_0001_1234_5678, 1'b1);
        issue(OP_LWU, 64'h2004, 64'd0, 5'd10, 0, 0, 64'h8000_0001_1234_5678, 1'b1);
        issue(OP_LH,  64'h3001, 64'd0, 5'd11, 1, 1, 64'hFEDC_BA98_7654_3210, 1'b1);
        issue(OP_SD,  64'h5008, 64'h0123_4567_89AB_CDEF, 5'd12, 3, 0, 64'd0, 1'b1);
        issue(OP_LD,  64'h6000, 64'd0, 5'd13, 0, TO + 4, 64'd0, 1'b1);
        issue(OP_SB,  64'h7000, 64'h55, 5'd14, TO + 1, 0, 64'd0, 1'b1);
        issue(7'b1_0_0011_0, 64'h8000, 64'd0, 5'd15, 0, 0, 64'd0, 1'b1);
        issue(7'b0_1_0001_0, 64'h9000, 64'd0, 5'd16, 0, 0, 64'd0, 1'b1);

        repeat (300) begin
            if ($urandom_range(0, 9) == 0) sz = 4'($urandom);
            else                          sz = 4'b0001 << $urandom_range(0, 3);
            op = {($urandom_range(0, 9) != 0), 1'($urandom), sz, 1'($urandom)};
            issue(op, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                  pick_dly(), pick_dly(), {$urandom, $urandom}, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        drain();

        issue(OP_LD, 64'h4000, 64'd0, 5'd3, 0, 1000, 64'd0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_mem_req", mif.mem_req, 0);
        chk("midrst_mem_we", mif.mem_we, 0);
        chk("midrst_mem_wmask", mif.mem_wmask, 0);
        chk("midrst_mem_addr", mif.mem_addr, 0);
        chk("midrst_mem_wdata", mif.mem_wdata, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_wb_we", wb_we, 0);
        chk("midrst_wb_rd", wb_rd, 0);
        chk("midrst_wb_data", wb_data, 0);
        chk("midrst_wb_err", wb_err, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("in_ready_after_midrst", in_ready, 1);
        repeat (3) begin
            chk("no_retry_after_reset", mif.mem_req, 0);
            @(negedge clock);
        end
        issue(OP_SB, 64'hA006, 64'h77, 5'd21, 0, 0, 64'd0, 1'b1);
        drain();
        chk("mem_q_empty", 64'(mem_q.size()), 0);
        chk("wb_q_empty", 64'(wb_q.size()), 0);
        finish_now();
    end
endmodule
